// File: rtl/cmd_ctrl_pkg.sv
// Shared constants and state encoding for the UART command controller.
// Command codes are 8-bit and get resized to the frame width at the point of use.
package cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] CMD_BRD     = 8'hEE;
  localparam logic [7:0] CMD_NACK    = 8'hFF;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT,
    S_BRD_ADDR,
    S_BRD_CNT,
    S_BRD_RD,
    S_BRD_WAIT,
    S_TX
  } state_t;

  // States that sit waiting on a frame or a response and are therefore timed.
  function automatic logic is_wait_state(input state_t s);
    return !((s == S_IDLE) || (s == S_BRD_RD) || (s == S_TX));
  endfunction

endpackage

// File: rtl/cmd_ctrl_txser.sv
// Byte serialiser toward the TX FIFO: holds up to two bytes, emits LS byte first,
// and stalls indefinitely while the FIFO reports full.
module cmd_ctrl_txser #(
  parameter int DATA_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_load,
  input  logic [2*DATA_W-1:0]   i_word,
  input  logic [1:0]            i_nbytes,
  input  logic                  i_ff_full,
  output logic [DATA_W-1:0]     o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_done
);

  logic [2*DATA_W-1:0] word_reg;
  logic [1:0]          left_reg;
  logic                push;

  // Data comes straight from a register; only the strobe is gated by full.
  assign push       = (left_reg != 2'd0) && !i_ff_full;
  assign o_tx_valid = push;
  assign o_tx_data  = word_reg[DATA_W-1:0];
  assign o_done     = push && (left_reg == 2'd1);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      word_reg <= '0;
      left_reg <= 2'd0;
    end else if (i_load) begin
      word_reg <= i_word;
      left_reg <= i_nbytes;
    end else if (push) begin
      word_reg <= word_reg >> DATA_W;
      left_reg <= left_reg - 2'd1;
    end
  end

endmodule

// File: rtl/cmd_ctrl_param.sv
// Second-generation UART command controller: frame decode, RF write/read,
// ALU sequencing, burst read, per-frame timeout and NACK reporting.
module cmd_ctrl_param
  import cmd_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int FUN_W   = 4,
  parameter int TO_W    = 16,
  parameter int TO_CYC  = 50000,
  parameter int NACK_EN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_rx_valid,
  input  logic [DATA_W-1:0]     i_rx_data,
  input  logic                  i_rd_valid,
  input  logic [DATA_W-1:0]     i_rd_data,
  input  logic                  i_alu_valid,
  input  logic [2*DATA_W-1:0]   i_alu_out,
  input  logic                  i_ff_full,
  output logic [ADDR_W-1:0]     o_address,
  output logic                  o_wr_en,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic                  o_rd_en,
  output logic                  o_alu_en,
  output logic [FUN_W-1:0]      o_alu_fun,
  output logic                  o_clk_en,
  output logic                  o_clk_div_en,
  output logic [DATA_W-1:0]     o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [DATA_W-1:0] C_WR      = DATA_W'(CMD_WR);
  localparam logic [DATA_W-1:0] C_RD      = DATA_W'(CMD_RD);
  localparam logic [DATA_W-1:0] C_ALU_OP  = DATA_W'(CMD_ALU_OP);
  localparam logic [DATA_W-1:0] C_ALU_NOP = DATA_W'(CMD_ALU_NOP);
  localparam logic [DATA_W-1:0] C_BRD     = DATA_W'(CMD_BRD);
  localparam logic [DATA_W-1:0] C_NACK    = DATA_W'(CMD_NACK);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);
  localparam logic [ADDR_W-1:0] A_OPA     = ADDR_W'(OPA_ADDR);
  localparam logic [ADDR_W-1:0] A_OPB     = ADDR_W'(OPB_ADDR);

  state_t                state_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [ADDR_W-1:0]     base_reg;
  logic [DATA_W-1:0]     off_reg;
  logic [DATA_W-1:0]     rem_reg;
  logic [2*DATA_W-1:0]   tx_word_reg;
  logic [1:0]            tx_nbytes_reg;
  logic                  tx_load_reg;
  logic [ADDR_W-1:0]     address_reg;
  logic                  wr_en_reg;
  logic [DATA_W-1:0]     wr_data_reg;
  logic                  rd_en_reg;
  logic                  alu_en_reg;
  logic [FUN_W-1:0]      alu_fun_reg;
  logic                  clk_en_reg;
  logic                  err_reg;

  logic                  evt;
  logic                  timeout;
  logic                  tx_done;

  // The event that a waiting state is blocked on; any other input is ignored there.
  always_comb begin
    evt = 1'b0;
    case (state_reg)
      S_RD_WAIT, S_BRD_WAIT: evt = i_rd_valid;
      S_ALU_WAIT:            evt = i_alu_valid;
      default:               evt = i_rx_valid;
    endcase
  end

  assign timeout = is_wait_state(state_reg) && !evt && (to_cnt_reg == TO_LAST);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg     <= S_IDLE;
      to_cnt_reg    <= '0;
      addr_reg      <= '0;
      base_reg      <= '0;
      off_reg       <= '0;
      rem_reg       <= '0;
      tx_word_reg   <= '0;
      tx_nbytes_reg <= 2'd0;
      tx_load_reg   <= 1'b0;
      address_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_data_reg   <= '0;
      rd_en_reg     <= 1'b0;
      alu_en_reg    <= 1'b0;
      alu_fun_reg   <= '0;
      clk_en_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      alu_en_reg  <= 1'b0;
      err_reg     <= 1'b0;
      tx_load_reg <= 1'b0;

      // Every exit from a waiting state is an event or a timeout, so clearing
      // whenever we do not simply keep waiting also covers state entry.
      if (is_wait_state(state_reg) && !evt && !timeout)
        to_cnt_reg <= to_cnt_reg + 1'b1;
      else
        to_cnt_reg <= '0;

      if (timeout) begin
        err_reg    <= 1'b1;
        clk_en_reg <= 1'b0;
        rem_reg    <= '0;
        if (NACK_EN != 0) begin
          tx_word_reg   <= {{DATA_W{1'b0}}, C_NACK};
          tx_nbytes_reg <= 2'd1;
          tx_load_reg   <= 1'b1;
          state_reg     <= S_TX;
        end else begin
          state_reg <= S_IDLE;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (i_rx_valid) begin
              case (i_rx_data)
                C_WR:  state_reg <= S_WR_ADDR;
                C_RD:  state_reg <= S_RD_ADDR;
                C_BRD: state_reg <= S_BRD_ADDR;
                C_ALU_OP: begin
                  clk_en_reg <= 1'b1;
                  state_reg  <= S_OPA;
                end
                C_ALU_NOP: begin
                  clk_en_reg <= 1'b1;
                  state_reg  <= S_FUN;
                end
                default: begin
                  err_reg <= 1'b1;
                  if (NACK_EN != 0) begin
                    tx_word_reg   <= {{DATA_W{1'b0}}, C_NACK};
                    tx_nbytes_reg <= 2'd1;
                    tx_load_reg   <= 1'b1;
                    state_reg     <= S_TX;
                  end
                end
              endcase
            end
          end

          S_WR_ADDR: if (i_rx_valid) begin
            addr_reg  <= i_rx_data[ADDR_W-1:0];
            state_reg <= S_WR_DATA;
          end

          S_WR_DATA: if (i_rx_valid) begin
            address_reg <= addr_reg;
            wr_data_reg <= i_rx_data;
            wr_en_reg   <= 1'b1;
            state_reg   <= S_IDLE;
          end

          S_RD_ADDR: if (i_rx_valid) begin
            address_reg <= i_rx_data[ADDR_W-1:0];
            rd_en_reg   <= 1'b1;
            state_reg   <= S_RD_WAIT;
          end

          S_RD_WAIT: if (i_rd_valid) begin
            tx_word_reg   <= {{DATA_W{1'b0}}, i_rd_data};
            tx_nbytes_reg <= 2'd1;
            tx_load_reg   <= 1'b1;
            state_reg     <= S_TX;
          end

          S_OPA: if (i_rx_valid) begin
            address_reg <= A_OPA;
            wr_data_reg <= i_rx_data;
            wr_en_reg   <= 1'b1;
            state_reg   <= S_OPB;
          end

          S_OPB: if (i_rx_valid) begin
            address_reg <= A_OPB;
            wr_data_reg <= i_rx_data;
            wr_en_reg   <= 1'b1;
            state_reg   <= S_FUN;
          end

          S_FUN: if (i_rx_valid) begin
            alu_fun_reg <= i_rx_data[FUN_W-1:0];
            alu_en_reg  <= 1'b1;
            state_reg   <= S_ALU_WAIT;
          end

          S_ALU_WAIT: if (i_alu_valid) begin
            tx_word_reg   <= i_alu_out;
            tx_nbytes_reg <= 2'd2;
            tx_load_reg   <= 1'b1;
            clk_en_reg    <= 1'b0;
            state_reg     <= S_TX;
          end

          S_BRD_ADDR: if (i_rx_valid) begin
            base_reg  <= i_rx_data[ADDR_W-1:0];
            state_reg <= S_BRD_CNT;
          end

          S_BRD_CNT: if (i_rx_valid) begin
            if (i_rx_data == '0) begin
              state_reg <= S_IDLE;
            end else begin
              rem_reg   <= i_rx_data;
              off_reg   <= '0;
              state_reg <= S_BRD_RD;
            end
          end

          // Address wraps naturally in ADDR_W bits.
          S_BRD_RD: begin
            address_reg <= base_reg + off_reg[ADDR_W-1:0];
            rd_en_reg   <= 1'b1;
            state_reg   <= S_BRD_WAIT;
          end

          S_BRD_WAIT: if (i_rd_valid) begin
            tx_word_reg   <= {{DATA_W{1'b0}}, i_rd_data};
            tx_nbytes_reg <= 2'd1;
            tx_load_reg   <= 1'b1;
            rem_reg       <= rem_reg - 1'b1;
            off_reg       <= off_reg + 1'b1;
            state_reg     <= S_TX;
          end

          S_TX: if (tx_done) begin
            state_reg <= (rem_reg != '0) ? S_BRD_RD : S_IDLE;
          end

          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  cmd_ctrl_txser #(
    .DATA_W (DATA_W)
  ) u_txser (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_load     (tx_load_reg),
    .i_word     (tx_word_reg),
    .i_nbytes   (tx_nbytes_reg),
    .i_ff_full  (i_ff_full),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (tx_done)
  );

  assign o_address    = address_reg;
  assign o_wr_en      = wr_en_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_rd_en      = rd_en_reg;
  assign o_alu_en     = alu_en_reg;
  assign o_alu_fun    = alu_fun_reg;
  assign o_clk_en     = clk_en_reg;
  assign o_clk_div_en = 1'b1;
  assign o_busy       = (state_reg != S_IDLE);
  assign o_err        = err_reg;

endmodule

// File: tb/tb_cmd_ctrl_param.sv
// Scoreboard bench for cmd_ctrl_param: stimulus pushes expected RF/ALU/FIFO
// activity into queues, an independent monitor pops them as the DUT acts.
module tb_cmd_ctrl_param;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int TW  = 16;
  localparam int TOC = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              i_rx_valid, i_rd_valid, i_alu_valid, i_ff_full;
  logic [DW-1:0]     i_rx_data, i_rd_data;
  logic [2*DW-1:0]   i_alu_out;
  logic [AW-1:0]     o_address;
  logic              o_wr_en, o_rd_en, o_alu_en, o_clk_en, o_clk_div_en;
  logic              o_tx_valid, o_busy, o_err;
  logic [DW-1:0]     o_wr_data, o_tx_data;
  logic [FW-1:0]     o_alu_fun;

  // Second instance without NACK reporting, driven only by its own RX inputs.
  logic              rx0_valid;
  logic [DW-1:0]     rx0_data;
  logic [AW-1:0]     o0_address;
  logic              o0_wr_en, o0_rd_en, o0_alu_en, o0_clk_en, o0_clk_div_en;
  logic              o0_tx_valid, o0_busy, o0_err;
  logic [DW-1:0]     o0_wr_data, o0_tx_data;
  logic [FW-1:0]     o0_alu_fun;

  cmd_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW), .TO_W(TW), .TO_CYC(TOC), .NACK_EN(1)) dut (
    .i_clk(clk), .i_arst(rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .i_alu_valid(i_alu_valid),
    .i_alu_out(i_alu_out), .i_ff_full(i_ff_full), .o_address(o_address),
    .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_rd_en(o_rd_en), .o_alu_en(o_alu_en),
    .o_alu_fun(o_alu_fun), .o_clk_en(o_clk_en), .o_clk_div_en(o_clk_div_en),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_err(o_err));

  cmd_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW), .TO_W(TW), .TO_CYC(TOC), .NACK_EN(0)) dut0 (
    .i_clk(clk), .i_arst(rst), .i_rx_valid(rx0_valid), .i_rx_data(rx0_data),
    .i_rd_valid(1'b0), .i_rd_data('0), .i_alu_valid(1'b0),
    .i_alu_out('0), .i_ff_full(1'b0), .o_address(o0_address),
    .o_wr_en(o0_wr_en), .o_wr_data(o0_wr_data), .o_rd_en(o0_rd_en), .o_alu_en(o0_alu_en),
    .o_alu_fun(o0_alu_fun), .o_clk_en(o0_clk_en), .o_clk_div_en(o0_clk_div_en),
    .o_tx_data(o0_tx_data), .o_tx_valid(o0_tx_valid), .o_busy(o0_busy), .o_err(o0_err));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state and scoreboard queues
  logic [7:0]  model_mem [16];
  logic [7:0]  rf_stub   [16];
  logic [7:0]  exp_tx [$];
  logic [11:0] exp_wr [$];
  logic [3:0]  exp_rd [$];
  logic [3:0]  exp_fun [$];
  int exp_err = 0, err_seen = 0, tx_count = 0, tx0_count = 0, err0_seen = 0;

  logic        alu_resp_en = 1'b1;
  logic        alu_ovr_en = 1'b0;
  logic [15:0] alu_ovr_val = 16'h0;
  int          ff_mode = 0;

  // Arbitrary external ALU behaviour, shared by the ALU stub and the prediction.
  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f[1:0])
      2'd0:    return {8'h00, a} + {8'h00, b};
      2'd1:    return a * b;
      2'd2:    return {a, b};
      default: return {b, a} ^ 16'h5A5A;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT acts
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_tx_valid) begin
          tx_count++;
          chk("tx_while_full", i_ff_full, 1'b0);
          if (exp_tx.size() == 0) begin
            total_cnt++;
            $display("FAIL tx_unexpected: got byte 0x%0h, none expected at %0t", o_tx_data, $time);
          end else chk("tx_data", o_tx_data, exp_tx.pop_front());
        end
        if (o_wr_en) begin
          rf_stub[o_address] = o_wr_data;
          if (exp_wr.size() == 0) begin
            total_cnt++;
            $display("FAIL wr_unexpected: got addr %0d data 0x%0h, none expected at %0t", o_address, o_wr_data, $time);
          end else chk("rf_write", {o_address, o_wr_data}, exp_wr.pop_front());
        end
        if (o_rd_en) begin
          if (exp_rd.size() == 0) begin
            total_cnt++;
            $display("FAIL rd_unexpected: got addr %0d, none expected at %0t", o_address, $time);
          end else chk("rf_read_addr", o_address, exp_rd.pop_front());
        end
        if (o_alu_en) begin
          chk("clk_en_at_alu_en", o_clk_en, 1'b1);
          if (exp_fun.size() == 0) begin
            total_cnt++;
            $display("FAIL alu_unexpected: got fun %0d, none expected at %0t", o_alu_fun, $time);
          end else chk("alu_fun", o_alu_fun, exp_fun.pop_front());
        end
        if (o_err) err_seen++;
        if (o0_tx_valid) tx0_count++;
        if (o0_err) err0_seen++;
      end
    end
  end

  // Register-file stub
  initial begin
    logic [3:0] a;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (o_rd_en && !rst) begin
        a = o_address;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        i_rd_valid = 1'b1;
        i_rd_data  = rf_stub[a];
        @(posedge clk);
        #1 i_rd_valid = 1'b0;
      end
    end
  end

  // ALU stub
  initial begin
    logic [3:0] f;
    i_alu_valid = 1'b0;
    i_alu_out   = '0;
    forever begin
      @(negedge clk);
      if (o_alu_en && !rst && alu_resp_en) begin
        f = o_alu_fun;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        i_alu_valid = 1'b1;
        i_alu_out   = alu_ovr_en ? alu_ovr_val : alu_model(f, rf_stub[0], rf_stub[1]);
        @(negedge clk);
        chk("clk_en_at_alu_valid", o_clk_en, 1'b1);
        @(posedge clk);
        #1 i_alu_valid = 1'b0;
      end
    end
  end

  // FIFO full driver: 0 = never full, 1 = held full, 2 = random
  initial begin
    i_ff_full = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ff_mode)
        0:       i_ff_full = 1'b0;
        1:       i_ff_full = 1'b1;
        default: i_ff_full = ($urandom_range(0, 9) < 3);
      endcase
    end
  end

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk);
    #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk);
    #1 i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!o_busy) return;
    end
    total_cnt++;
    $display("FAIL busy_timeout: o_busy still 1 after 3000 cycles, required 0 at %0t", $time);
  endtask

  function automatic logic [7:0] afr(input logic [3:0] a);
    logic [3:0] hi;
    hi = 4'($urandom);
    return {hi, a};
  endfunction

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model_mem[a] = d;
    send(8'hAA); send(afr(a)); send(d);
    wait_idle();
  endtask

  task automatic do_rd(input logic [3:0] a);
    exp_rd.push_back(a);
    exp_tx.push_back(model_mem[a]);
    send(8'hBB); send(afr(a));
    wait_idle();
  endtask

  task automatic push_alu_result(input logic [3:0] f);
    logic [15:0] r;
    r = alu_ovr_en ? alu_ovr_val : alu_model(f, model_mem[0], model_mem[1]);
    exp_fun.push_back(f);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic do_alu(input logic [7:0] x, input logic [7:0] y, input logic [3:0] f);
    exp_wr.push_back({4'd0, x});
    exp_wr.push_back({4'd1, y});
    model_mem[0] = x;
    model_mem[1] = y;
    push_alu_result(f);
    send(8'hCC); send(x); send(y); send(afr(f));
    wait_idle();
  endtask

  task automatic do_nop(input logic [3:0] f);
    push_alu_result(f);
    send(8'hDD); send(afr(f));
    wait_idle();
  endtask

  task automatic do_brd(input logic [3:0] b, input logic [7:0] n);
    logic [3:0] a;
    for (int k = 0; k < int'(n); k++) begin
      a = b + 4'(k);
      exp_rd.push_back(a);
      exp_tx.push_back(model_mem[a]);
    end
    send(8'hEE); send(afr(b)); send(n);
    wait_idle();
  endtask

  task automatic do_bad(input logic [7:0] c);
    exp_tx.push_back(8'hFF);
    exp_err++;
    send(c);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tx_before, err_before, sel;
    logic [7:0] v;
    logic [7:0] bad_codes [4];
    bad_codes[0] = 8'h00; bad_codes[1] = 8'h11; bad_codes[2] = 8'h55; bad_codes[3] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      model_mem[i] = v;
      rf_stub[i]   = v;
    end
    rst = 1'b1;
    i_rx_valid = 1'b0; i_rx_data = '0;
    rx0_valid = 1'b0; rx0_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {o_wr_en, o_rd_en, o_alu_en, o_tx_valid, o_err, o_clk_en, o_busy}, 7'd0);
    chk("rst_clk_div_en", o_clk_div_en, 1'b1);
    chk("rst_address", o_address, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 1'b0);

    // Single write, back to IDLE right after the data frame
    exp_wr.push_back({4'd5, 8'h3C});
    model_mem[5] = 8'h3C;
    send(8'hAA); send(8'h05); send(8'h3C);
    @(negedge clk);
    chk("wr_back_to_idle", o_busy, 1'b0);

    // ALU_OP with a fixed ALU response
    alu_ovr_en = 1'b1; alu_ovr_val = 16'h0246;
    exp_wr.push_back({4'd0, 8'h12});
    exp_wr.push_back({4'd1, 8'h34});
    model_mem[0] = 8'h12; model_mem[1] = 8'h34;
    push_alu_result(4'd2);
    send(8'hCC);
    @(negedge clk);
    chk("clk_en_after_cmd", o_clk_en, 1'b1);
    send(8'h12); send(8'h34); send(8'h02);
    wait_idle();
    chk("clk_en_after_alu", o_clk_en, 1'b0);
    alu_ovr_en = 1'b0;

    // Burst read wrapping past the top address
    do_wr(4'd14, 8'hA0); do_wr(4'd15, 8'hA1); do_wr(4'd0, 8'hA2);
    do_brd(4'd14, 8'd3);

    // Backpressure: RF response while FIFO is full, plus a frame dropped in TX
    @(posedge clk);
    #1 ff_mode = 1;
    tx_before = tx_count;
    err_before = err_seen;
    exp_rd.push_back(4'd7);
    exp_tx.push_back(model_mem[7]);
    send(8'hBB); send(8'h07);
    repeat (10) @(posedge clk);
    send(8'hAA);
    repeat (12) @(negedge clk);
    chk("bp_no_push", tx_count, tx_before);
    chk("bp_busy_held", o_busy, 1'b1);
    @(posedge clk);
    #1 ff_mode = 0;
    @(negedge clk);
    chk("bp_first_push", o_tx_valid, 1'b1);
    wait_idle();
    chk("bp_single_push", tx_count, tx_before + 1);
    chk("bp_no_timeout", err_seen, err_before);

    // Timeout in WR_DATA
    exp_tx.push_back(8'hFF);
    exp_err++;
    send(8'hAA); send(8'h05);
    n = 0;
    for (int i = 1; i <= 3 * TOC; i++) begin
      @(negedge clk);
      if (o_err) begin n = i; break; end
    end
    chk("timeout_cycle", n, TOC + 1);
    @(negedge clk);
    chk("timeout_err_pulse", o_err, 1'b0);
    wait_idle();

    // Unknown command with and without NACK reporting
    @(posedge clk);
    #1; rx0_valid = 1'b1; rx0_data = 8'h11;
    @(posedge clk);
    #1 rx0_valid = 1'b0;
    @(negedge clk);
    chk("nonack_err", o0_err, 1'b1);
    chk("nonack_idle", o0_busy, 1'b0);
    @(negedge clk);
    chk("nonack_err_pulse", o0_err, 1'b0);
    do_bad(8'h11);

    // Reset while waiting for the ALU: silent abort, operands stay written
    alu_resp_en = 1'b0;
    exp_wr.push_back({4'd0, 8'h5A});
    exp_wr.push_back({4'd1, 8'hC3});
    model_mem[0] = 8'h5A; model_mem[1] = 8'hC3;
    exp_fun.push_back(4'd1);
    send(8'hCC); send(8'h5A); send(8'hC3); send(8'h01);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_strobes", {o_wr_en, o_rd_en, o_alu_en, o_tx_valid, o_err, o_clk_en, o_busy}, 7'd0);
    chk("arst_clk_div_en", o_clk_div_en, 1'b1);
    chk("arst_address", o_address, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    alu_resp_en = 1'b1;

    // Randomised command mix with random FIFO backpressure
    @(posedge clk);
    #1 ff_mode = 2;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    do_wr(4'($urandom), 8'($urandom));
        2, 3:    do_rd(4'($urandom));
        4:       do_alu(8'($urandom), 8'($urandom), 4'($urandom));
        5:       do_nop(4'($urandom));
        6, 7, 8: do_brd(4'($urandom), 8'($urandom_range(0, 5)));
        default: do_bad(bad_codes[$urandom_range(0, 3)]);
      endcase
    end
    @(posedge clk);
    #1 ff_mode = 0;
    wait_idle();
    repeat (10) @(negedge clk);

    chk("end_tx_queue", exp_tx.size(), 0);
    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_rd_queue", exp_rd.size(), 0);
    chk("end_fun_queue", exp_fun.size(), 0);
    chk("end_err_count", err_seen, exp_err);
    chk("end_nonack_tx", tx0_count, 0);
    chk("end_nonack_err", err0_seen, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cmd_ctrl_param.md
Name: cmd_ctrl_param

Overview:
Parametrised second-generation UART command controller. It sits between the RX master and the register file, ALU, clock gate and TX FIFO. It decodes command frames, drives RF write/read, loads operands and runs the ALU, and serialises results into the TX FIFO. Over the first generation it adds:
- width generics
- a burst-read command
- a per-frame timeout
- NACK reporting for unknown or aborted commands

Parameters:
DATA_W, 8, frame/RF data width; ALU result is 2*DATA_W
ADDR_W, 4, RF address width
FUN_W, 4, ALU function code width
TO_W, 16, timeout counter width
TO_CYC, 50000, idle cycles allowed while waiting for a frame or a response before abort (must be < 2^TO_W)
NACK_EN, 1, 1 = push NACK byte on unknown command or timeout

Ports:
i_clk  in  1  system clock
i_arst  in  1  asynchronous active-high reset
i_rx_valid  in  1  RX frame valid, one-cycle pulse
i_rx_data  in  DATA_W  RX frame
i_rd_valid  in  1  RF read data valid
i_rd_data  in  DATA_W  RF read data
i_alu_valid  in  1  ALU result valid
i_alu_out  in  2*DATA_W  ALU result
i_ff_full  in  1  TX FIFO full
o_address  out  ADDR_W  RF address
o_wr_en  out  1  RF write strobe
o_wr_data  out  DATA_W  RF write data
o_rd_en  out  1  RF read strobe
o_alu_en  out  1  ALU enable
o_alu_fun  out  FUN_W  ALU function
o_clk_en  out  1  ALU clock-gate enable
o_clk_div_en  out  1  UART divider enable
o_tx_data  out  DATA_W  FIFO write data
o_tx_valid  out  1  FIFO write (winc)
o_busy  out  1  high in every state except IDLE
o_err  out  1  one-cycle pulse on timeout or unknown command

Behaviour:
- Reset: all outputs 0 except o_clk_div_en=1; state IDLE; counters and holding registers 0. Reset mid-operation aborts silently: no NACK, no FIFO write.
- Command codes (low DATA_W bits): WR=0xAA, RD=0xBB, ALU_OP=0xCC, ALU_NOP=0xDD, BRD=0xEE, NACK=0xFF.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, BRD_ADDR, BRD_CNT, BRD_RD, BRD_WAIT, TX.
- WR: IDLE -0xAA-> WR_ADDR -frame-> WR_DATA (latch addr = frame[ADDR_W-1:0]) -frame-> o_wr_en=1 for one cycle with latched addr/data, then IDLE. No FIFO output.
- RD: RD_ADDR -frame-> one-cycle o_rd_en with the addr -> RD_WAIT. On i_rd_valid, latch one byte -> TX with byte count 1.
- ALU_OP: OPA frame -> RF write to addr 0. OPB frame -> RF write to addr 1. FUN frame -> one-cycle o_alu_en with o_alu_fun=frame[FUN_W-1:0] -> ALU_WAIT.
- ALU_NOP: IDLE goes directly to FUN.
- o_clk_en is high from the cycle the 0xCC/0xDD frame is accepted until ALU_WAIT exits.
- ALU_WAIT: on i_alu_valid, latch the 2*DATA_W result -> TX with byte count 2.
- BRD: BRD_ADDR latches base, BRD_CNT latches count N (0..2^DATA_W-1).
  - N=0 returns to IDLE with no reads.
  - Otherwise, for k=0..N-1: o_rd_en pulse at addr (base+k) mod 2^ADDR_W; wait i_rd_valid; push 1 byte via TX; return to BRD_RD until k=N-1, then IDLE.
- TX: bytes are sent LS byte first. o_tx_valid = !i_ff_full for exactly one cycle per byte, with o_tx_data registered-stable. While i_ff_full=1, the controller holds the current byte indefinitely; FIFO backpressure never times out. After the last byte it returns to IDLE (or BRD_RD).
- Unknown command byte in IDLE: o_err pulse; if NACK_EN, TX pushes 0xFF (1 byte); else stays in IDLE.
- Timeout: counter resets on state entry and on every accepted frame or valid response. In any state waiting on i_rx_valid, i_rd_valid or i_alu_valid, reaching TO_CYC cycles -> o_err pulse, then NACK via TX (if NACK_EN) or IDLE. Partial WR/ALU operands already written stay written.
- i_rx_valid in TX, RD_WAIT, ALU_WAIT, BRD_RD or BRD_WAIT is dropped; o_busy flags this to upstream.
- Simultaneous i_rd_valid or i_alu_valid outside its wait state is ignored.
- Widths: address arithmetic wraps modulo 2^ADDR_W; the burst counter is DATA_W wide.

Decomposition:
- Package cmd_ctrl_pkg: command code constants, NACK code, state enum, operand addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module, cmd_ctrl_txser: holds up to 2*DATA_W bits plus a byte count, and emits bytes under i_ff_full backpressure with a done flag.
- The FSM, timeout counter and burst counter stay in cmd_ctrl_param.

Test Plan:
- WR: 0xAA,0x05,0x3C -> single o_wr_en with o_address=5, o_wr_data=0x3C; no o_tx_valid; returns to IDLE (o_busy=0).
- ALU_OP: 0xCC,0x12,0x34,0x02 with i_alu_out=0x0246 -> RF writes (0,0x12) and (1,0x34); o_alu_en with o_alu_fun=2; FIFO gets 0x46 then 0x02; o_clk_en high throughout.
- BRD with wrap: 0xEE,0x0E,0x03 with RF returning 0xA0/0xA1/0xA2 -> reads at addresses 14,15,0; FIFO gets 0xA0,0xA1,0xA2.
- Backpressure: during RD response hold i_ff_full=1 for 20 cycles -> no o_tx_valid; single push of the byte on the first not-full cycle; no timeout.
- Timeout: 0xAA,0x05 then silence with TO_CYC=100 -> o_err pulse at cycle 100 after the last frame; FIFO gets 0xFF; IDLE; no o_wr_en.
- Unknown command 0x11 with NACK_EN=0 -> o_err pulse, no FIFO write, stays in IDLE. Assert i_arst mid-ALU_WAIT -> all outputs at reset values immediately, o_clk_div_en=1.
